eviction_drain_arbiter: RTL and testbench

//  Sits between the L2 cache's memory port and physical memory, directly downstream of the single-entry

---
 rtl/ewb_pkg.sv | 18 +
 rtl/eviction_drain_arbiter.sv | 132 +++++++++++++
 tb/tb_eviction_drain_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ewb_pkg.sv
// Shared types and default sizing for the eviction write-buffer drain arbiter.
package ewb_pkg;

  localparam int LINE_W     = 256;
  localparam int OFFSET_W   = 5;
  localparam int BYPASS_MAX = 4;

  typedef logic [LINE_W-1:0] line_t;

  typedef enum logic [2:0] {
    IDLE,
    FWD,
    READ,
    ACCEPT,
    DRAIN
  } state_e;

endpackage

// File: rtl/eviction_drain_arbiter.sv
// Arbitrates the L2 memory port between line reads, buffer forwarding, eviction
// acceptance and draining of the single-entry write buffer to physical memory.
module eviction_drain_arbiter #(
  parameter int LINE_W     = ewb_pkg::LINE_W,
  parameter int OFFSET_W   = ewb_pkg::OFFSET_W,
  parameter int BYPASS_MAX = ewb_pkg::BYPASS_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       mem_address,
  input  logic [LINE_W-1:0] mem_wdata,
  output logic [LINE_W-1:0] mem_rdata,
  output logic              mem_resp,
  input  logic              buf_valid,
  input  logic [31:0]       buf_address,
  input  logic [LINE_W-1:0] buf_wdata,
  output logic              buf_write,
  output logic [LINE_W-1:0] buf_wdata_in,
  output logic [31:0]       buf_address_in,
  output logic              complete_eviction,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [31:0]       pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);
  import ewb_pkg::*;

  localparam int CNT_W = $clog2(BYPASS_MAX + 1);

  state_e           state;
  logic [CNT_W-1:0] bypass_cnt;
  logic [31:0]      pmem_addr_q;
  logic             pmem_read_q;
  logic             pmem_write_q;
  logic             buf_write_q;
  logic             fwd_resp_q;

  logic        hit;
  logic        drain_due;
  logic [31:0] mem_line;
  logic [31:0] buf_line;
  logic        unused_buf_offset;

  assign hit       = buf_valid && (mem_address[31:OFFSET_W] == buf_address[31:OFFSET_W]);
  assign drain_due = buf_valid && (bypass_cnt == CNT_W'(BYPASS_MAX));
  assign mem_line  = {mem_address[31:OFFSET_W], {OFFSET_W{1'b0}}};
  assign buf_line  = {buf_address[31:OFFSET_W], {OFFSET_W{1'b0}}};
  assign unused_buf_offset = ^buf_address[OFFSET_W-1:0];

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bypass_cnt   <= '0;
      pmem_addr_q  <= '0;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      buf_write_q  <= 1'b0;
      fwd_resp_q   <= 1'b0;
    end else begin
      buf_write_q <= 1'b0;
      fwd_resp_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mem_read && hit) begin
            state      <= FWD;
            fwd_resp_q <= 1'b1;
          end else if (drain_due) begin
            state        <= DRAIN;
            pmem_write_q <= 1'b1;
            pmem_addr_q  <= buf_line;
          end else if (mem_read) begin
            state       <= READ;
            pmem_read_q <= 1'b1;
            pmem_addr_q <= mem_line;
          end else if (mem_write && !buf_valid) begin
            state       <= ACCEPT;
            buf_write_q <= 1'b1;
          end else if (buf_valid) begin
            // A stalled eviction lands here: drain first, accept afterwards.
            state        <= DRAIN;
            pmem_write_q <= 1'b1;
            pmem_addr_q  <= buf_line;
          end
        end
        FWD, ACCEPT: state <= IDLE;
        READ: begin
          if (pmem_resp) begin
            state       <= IDLE;
            pmem_read_q <= 1'b0;
            pmem_addr_q <= '0;
            if (buf_valid && (bypass_cnt != CNT_W'(BYPASS_MAX)))
              bypass_cnt <= bypass_cnt + CNT_W'(1);
          end
        end
        DRAIN: begin
          if (pmem_resp) begin
            state        <= IDLE;
            pmem_write_q <= 1'b0;
            pmem_addr_q  <= '0;
            bypass_cnt   <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read completion is passed through the same cycle pmem answers.
  assign mem_resp          = fwd_resp_q | buf_write_q | (pmem_read_q & pmem_resp);
  assign mem_rdata         = fwd_resp_q                 ? buf_wdata  :
                             (pmem_read_q && pmem_resp) ? pmem_rdata : '0;
  assign complete_eviction = pmem_write_q & pmem_resp;
  assign buf_write         = buf_write_q;
  assign buf_wdata_in      = mem_wdata;
  assign buf_address_in    = mem_address;
  assign pmem_read         = pmem_read_q;
  assign pmem_write        = pmem_write_q;
  assign pmem_address      = pmem_addr_q;
  assign pmem_wdata        = pmem_write_q ? buf_wdata : '0;

  a_no_read_and_write: assert property (@(posedge clk) disable iff (rst)
    !(mem_read && mem_write));
  a_pmem_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(pmem_read && pmem_write));

endmodule

// File: tb/tb_eviction_drain_arbiter.sv
// Directed bench for eviction_drain_arbiter with a transaction-level reference
// model compared every cycle, plus scenario-level literal expectations.
module tb_eviction_drain_arbiter;
  import ewb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] mem_address;
  line_t       mem_wdata, mem_rdata;
  logic        mem_resp;
  logic        buf_valid;
  logic [31:0] buf_address;
  line_t       buf_wdata, buf_wdata_in;
  logic        buf_write;
  logic [31:0] buf_address_in;
  logic        complete_eviction;
  logic        pmem_read, pmem_write;
  logic [31:0] pmem_address;
  line_t       pmem_wdata, pmem_rdata;
  logic        pmem_resp;

  eviction_drain_arbiter dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .buf_valid(buf_valid), .buf_address(buf_address), .buf_wdata(buf_wdata),
    .buf_write(buf_write), .buf_wdata_in(buf_wdata_in), .buf_address_in(buf_address_in),
    .complete_eviction(complete_eviction),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_str(input string name, input string got, input string exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got \"%s\", expected \"%s\"", name, got, exp);
    end
  endtask

  function automatic line_t mem_data(input logic [31:0] a);
    return {8{a ^ 32'hC0DE_0000}};
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & ~32'h1F;
  endfunction

  // Reference model: what the arbiter is currently serving, and the bypass tally.
  typedef enum int {J_NONE, J_FWD, J_READ, J_ACCEPT, J_DRAIN} job_e;
  job_e        m_job = J_NONE;
  int          m_cnt = 0;
  logic [31:0] m_addr = '0;

  // Observation log shared with the scenario code.
  string       ev_log = "";
  int          n_ce = 0, n_reads = 0;
  logic        pw_prev = 1'b0, pr_prev = 1'b0;
  logic [31:0] last_w_addr = '0;
  line_t       last_w_data = '0;
  int          pw_run = 0, last_drain_len = 0;
  logic        bw_seen = 1'b0, ce_seen = 1'b0;
  logic [31:0] bw_addr = '0;
  line_t       bw_data = '0;

  always @(negedge clk) begin : cmp
    logic        e_resp, e_bw, e_ce, e_pr, e_pw, m_hit;
    line_t       e_rdata;
    e_resp = 1'b0; e_bw = 1'b0; e_ce = 1'b0; e_pr = 1'b0; e_pw = 1'b0;
    e_rdata = '0;
    if (rst) begin
      m_job = J_NONE;
      m_cnt = 0;
    end
    case (m_job)
      J_FWD:    begin e_resp = 1'b1; e_rdata = buf_wdata; end
      J_ACCEPT: begin e_resp = 1'b1; e_bw = 1'b1; end
      J_READ:   begin
        e_pr = 1'b1;
        if (pmem_resp) begin e_resp = 1'b1; e_rdata = pmem_rdata; end
      end
      J_DRAIN:  begin e_pw = 1'b1; e_ce = pmem_resp; end
      default:  ;
    endcase
    check("mem_resp", mem_resp, e_resp);
    check("buf_write", buf_write, e_bw);
    check("complete_eviction", complete_eviction, e_ce);
    check("pmem_read", pmem_read, e_pr);
    check("pmem_write", pmem_write, e_pw);
    check("buf_address_in", buf_address_in, mem_address);
    check("buf_wdata_in", buf_wdata_in, mem_wdata);
    if (e_resp) check("mem_rdata", mem_rdata, e_rdata);
    if (e_pr || e_pw) check("pmem_address", pmem_address, m_addr);
    if (e_pw) check("pmem_wdata", pmem_wdata, buf_wdata);

    // Event log and buffer-side sampling.
    if (pmem_write && !pw_prev) begin
      ev_log = {ev_log, "W"};
      last_w_addr = pmem_address;
      last_w_data = pmem_wdata;
    end
    if (pmem_read && !pr_prev) begin
      ev_log = {ev_log, "R"};
      n_reads++;
    end
    pw_run = pmem_write ? pw_run + 1 : 0;
    if (complete_eviction) begin
      ev_log = {ev_log, "C"};
      n_ce++;
      last_drain_len = pw_run;
    end
    if (buf_write) ev_log = {ev_log, "B"};
    pw_prev = pmem_write;
    pr_prev = pmem_read;
    bw_seen = buf_write;
    ce_seen = complete_eviction;
    bw_addr = buf_address_in;
    bw_data = buf_wdata_in;

    // Advance the model to what must be served after the coming edge.
    if (!rst) begin
      m_hit = buf_valid && (mem_address[31:5] == buf_address[31:5]);
      case (m_job)
        J_NONE: begin
          if (mem_read && m_hit)                   m_job = J_FWD;
          else if (buf_valid && m_cnt == BYPASS_MAX) begin m_job = J_DRAIN; m_addr = align(buf_address); end
          else if (mem_read)                       begin m_job = J_READ;  m_addr = align(mem_address); end
          else if (mem_write && !buf_valid)        m_job = J_ACCEPT;
          else if (buf_valid)                      begin m_job = J_DRAIN; m_addr = align(buf_address); end
        end
        J_FWD, J_ACCEPT: m_job = J_NONE;
        J_READ: if (pmem_resp) begin
          if (buf_valid && m_cnt < BYPASS_MAX) m_cnt++;
          m_job = J_NONE;
        end
        J_DRAIN: if (pmem_resp) begin
          m_cnt = 0;
          m_job = J_NONE;
        end
        default: m_job = J_NONE;
      endcase
    end
  end

  // Write buffer: loads on buf_write, clears on complete_eviction, ignores rst.
  always begin
    @(posedge clk);
    #1;
    if (ce_seen) buf_valid = 1'b0;
    if (bw_seen) begin
      buf_valid   = 1'b1;
      buf_address = bw_addr;
      buf_wdata   = bw_data;
    end
  end

  // Physical memory: answers after pmem_lat cycles of a held request.
  int pmem_lat = 5;
  int pcnt = 0;
  always begin
    @(posedge clk);
    #1;
    if (rst || pmem_resp) begin
      pmem_resp = 1'b0;
      pcnt = 0;
    end else if (pmem_read || pmem_write) begin
      pcnt++;
      if (pcnt >= pmem_lat) begin
        pmem_resp  = 1'b1;
        pmem_rdata = mem_data(pmem_address);
      end
    end
  end

  // Cache-side drivers; called just after a rising edge, return just after one.
  task automatic do_read(input logic [31:0] a, output line_t d, output int lat);
    logic done = 1'b0;
    mem_read = 1'b1; mem_address = a; lat = 0; d = '0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (mem_resp) begin d = mem_rdata; done = 1'b1; end
    end
    check("read_resp_seen", done, 1'b1);
    @(posedge clk); #1;
    mem_read = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input line_t d, output int lat, output logic bw);
    logic done = 1'b0;
    mem_write = 1'b1; mem_address = a; mem_wdata = d; lat = 0; bw = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      lat++;
      if (mem_resp) begin bw = buf_write; done = 1'b1; end
    end
    check("write_resp_seen", done, 1'b1);
    @(posedge clk); #1;
    mem_write = 1'b0; mem_wdata = '0;
  endtask

  task automatic wait_drain(input string name);
    int start = n_ce;
    logic done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk); #1;
      if (n_ce > start) done = 1'b1;
    end
    check(name, done, 1'b1);
  endtask

  task automatic preload(input logic [31:0] a, input line_t d);
    buf_valid = 1'b1; buf_address = a; buf_wdata = d;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    line_t d;
    int lat, ce0, r0;
    logic bw, pw_seen;
    mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_wdata = '0;
    buf_valid = 1'b0; buf_address = '0; buf_wdata = '0;
    pmem_resp = 1'b0; pmem_rdata = '0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t1_idle_ctrl", {mem_resp, buf_write, complete_eviction, pmem_read, pmem_write}, 5'b0);
      check("t1_idle_addr", pmem_address, 32'h0);
    end
    @(posedge clk); #1;

    // 2: accept into empty buffer, then drain with a 5-cycle pmem
    pmem_lat = 5;
    ce0 = n_ce;
    do_write(32'h1000_0040, mem_data(32'h1111_0000), lat, bw);
    check("t2_bw_with_resp", bw, 1'b1);
    check("t2_accept_latency", lat, 2);
    @(negedge clk);
    check("t2_one_wide", {mem_resp, buf_write}, 2'b00);
    wait_drain("t2_drain_done");
    check("t2_drain_addr", last_w_addr, 32'h1000_0040);
    check("t2_drain_data", last_w_data, mem_data(32'h1111_0000));
    check("t2_drain_len", last_drain_len, 5);
    repeat (3) @(posedge clk); #1;
    check("t2_one_complete", n_ce - ce0, 1);

    // 3: read hit forwards from the buffer without touching pmem
    r0 = n_reads;
    preload(32'h2000_0020, mem_data(32'h2222_0000));
    do_read(32'h2000_003C, d, lat);
    check("t3_fwd_data", d, mem_data(32'h2222_0000));
    check("t3_fwd_latency", lat, 2);
    check("t3_no_pmem_read", n_reads - r0, 0);
    wait_drain("t3_drain_done");

    // 4: bounded bypass forces a drain before the fifth read
    pmem_lat = 2;
    ev_log = "";
    preload(32'h3000_0000, mem_data(32'h3333_0000));
    for (int i = 0; i < 6; i++) begin
      do_read(32'h4000_0010 + 32'(i) * 32'h100, d, lat);
      check("t4_read_data", d, mem_data(32'h4000_0000 + 32'(i) * 32'h100));
    end
    check_str("t4_order", ev_log, "RRRRWCRR");
    check("t4_bypass_cleared", dut.bypass_cnt, 0);

    // 5: eviction into a full buffer waits for the drain
    pmem_lat = 3;
    ev_log = "";
    preload(32'h5000_0000, mem_data(32'h5555_0000));
    do_write(32'h6000_0000, mem_data(32'h6666_0000), lat, bw);
    check("t5_bw_with_resp", bw, 1'b1);
    check("t5_stall_latency", lat, 6);
    check_str("t5_order", ev_log, "WCB");
    wait_drain("t5_drain_done");
    check("t5_new_line_addr", last_w_addr, 32'h6000_0000);
    check("t5_new_line_data", last_w_data, mem_data(32'h6666_0000));

    // 6: reset mid-drain, drain reissues afterwards
    pmem_lat = 8;
    preload(32'h7000_0040, mem_data(32'h7777_0000));
    pw_seen = 1'b0;
    for (int i = 0; i < 20 && !pw_seen; i++) begin
      @(posedge clk); #1;
      if (pmem_write) pw_seen = 1'b1;
    end
    check("t6_drain_started", pw_seen, 1'b1);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_async_drop", {pmem_write, complete_eviction}, 2'b00);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ev_log = "";
    ce0 = n_ce;
    wait_drain("t6_redrain_done");
    check("t6_redrain_addr", last_w_addr, 32'h7000_0040);
    check("t6_redrain_data", last_w_data, mem_data(32'h7777_0000));
    check("t6_redrain_len", last_drain_len, 8);
    check_str("t6_order", ev_log, "WC");
    check("t6_one_complete", n_ce - ce0, 1);

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
